uart_tx_word: RTL and testbench

//  UART 8N1 transmitter; the outbound counterpart of the instruction-load receiver.

---
 rtl/uart_tx_word_pkg.sv | 24 ++
 rtl/uart_tx_byte.sv | 106 ++++++++++
 rtl/uart_tx_word.sv | 92 +++++++++
 tb/tb_uart_tx_word.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_word_pkg.sv
// Shared constants and state types for the word-wide UART 8N1 transmitter.
// The baud constants live here so the receiver can import the same values
// and both ends of the link always agree on the line rate.
package uart_tx_word_pkg;

    localparam int UART_CLK_FREQ   = 50_000_000;
    localparam int UART_BAUD       = 115_200;
    localparam int UART_WORD_BYTES = 4;

    // Byte serializer states
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Outer word sequencer states
    typedef enum logic {
        WORD_IDLE = 1'b0,
        WORD_SEND = 1'b1
    } word_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// Byte serializer: baud counter plus START/DATA/STOP framing for one 8N1 byte.
// byte_ready is also raised in the last cycle of a stop bit, so a waiting
// byte is taken straight into a new start bit with no idle gap between frames.
// byte_done pulses for one cycle only when the serializer drops back to idle.
module uart_tx_byte
    import uart_tx_word_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst_p,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx_line,
    output logic       byte_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         state_reg;
    logic [BAUD_W-1:0] baud_cnt_reg;
    logic [2:0]        bit_cnt_reg;
    logic [7:0]        shift_reg;
    logic              tx_reg;
    logic              done_reg;
    logic              bit_end;

    assign bit_end    = (baud_cnt_reg == BAUD_LAST);
    assign byte_ready = (state_reg == TX_IDLE) || ((state_reg == TX_STOP) && bit_end);
    assign tx_line    = tx_reg;
    assign byte_done  = done_reg;

    // Framing FSM; the line level is registered so it only moves on bit boundaries
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state_reg    <= TX_IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                TX_IDLE: begin
                    if (byte_valid) begin
                        state_reg    <= TX_START;
                        shift_reg    <= byte_data;
                        baud_cnt_reg <= '0;
                        bit_cnt_reg  <= '0;
                        tx_reg       <= 1'b0;
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        state_reg    <= TX_DATA;
                        baud_cnt_reg <= '0;
                        bit_cnt_reg  <= '0;
                        tx_reg       <= shift_reg[0];
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= TX_STOP;
                            tx_reg    <= 1'b1;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            shift_reg   <= shift_reg >> 1;
                            tx_reg      <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        bit_cnt_reg  <= '0;
                        if (byte_valid) begin
                            // Chain the next byte directly into a start bit
                            state_reg <= TX_START;
                            shift_reg <= byte_data;
                            tx_reg    <= 1'b0;
                        end else begin
                            state_reg <= TX_IDLE;
                            done_reg  <= 1'b1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= TX_IDLE;
                    tx_reg    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_word.sv
// Word-wide UART 8N1 transmitter. Accepts one word over valid/ready and sends
// its bytes least-significant first as back-to-back frames on one line.
// Byte 0 goes to the serializer in the accept cycle itself, so the start bit
// appears one cycle after accept; the remaining bytes wait in word_reg and
// are shifted down one byte each time the serializer chains a new frame.
module uart_tx_word
    import uart_tx_word_pkg::*;
#(
    parameter int CLK_FREQ   = UART_CLK_FREQ,
    parameter int BAUD_RATE  = UART_BAUD,
    parameter int WORD_BYTES = UART_WORD_BYTES
) (
    input  logic                    clk,
    input  logic                    rst_p,
    input  logic                    word_valid,
    input  logic [WORD_BYTES*8-1:0] word_data,
    output logic                    word_ready,
    output logic                    uart_tx,
    output logic                    tx_busy,
    output logic                    tx_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int BYTE_W       = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(WORD_BYTES - 1);

    word_state_t             state_reg;
    logic [WORD_BYTES*8-1:0] word_reg;
    logic [BYTE_W-1:0]       byte_cnt_reg;
    logic                    byte_valid;
    logic                    byte_ready;
    logic [7:0]              byte_data;

    assign word_ready = (state_reg == WORD_IDLE);
    assign tx_busy    = (state_reg != WORD_IDLE);

    // Byte feed: straight from word_data on accept, then from the held remainder
    always_comb begin
        byte_valid = 1'b0;
        byte_data  = word_reg[7:0];
        if (state_reg == WORD_IDLE) begin
            byte_valid = word_valid;
            byte_data  = word_data[7:0];
        end else begin
            byte_valid = (byte_cnt_reg != BYTE_LAST);
        end
    end

    // Word sequencer: latches the word on accept and tracks which byte is on the line
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state_reg    <= WORD_IDLE;
            word_reg     <= '0;
            byte_cnt_reg <= '0;
        end else begin
            case (state_reg)
                WORD_IDLE: begin
                    if (word_valid) begin
                        state_reg    <= WORD_SEND;
                        word_reg     <= word_data >> 8;
                        byte_cnt_reg <= '0;
                    end
                end
                WORD_SEND: begin
                    // byte_ready is only seen here at the end of a stop bit
                    if (byte_ready) begin
                        if (byte_cnt_reg != BYTE_LAST) begin
                            byte_cnt_reg <= byte_cnt_reg + 1'b1;
                            word_reg     <= word_reg >> 8;
                        end else begin
                            state_reg <= WORD_IDLE;
                        end
                    end
                end
                default: state_reg <= WORD_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk       (clk),
        .rst_p     (rst_p),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .tx_line   (uart_tx),
        .byte_done (tx_done)
    );

endmodule

// File: tb/tb_uart_tx_word.sv
// Bench for uart_tx_word at 10 clocks per bit. Stimulus pushes hand-computed
// bytes into a scoreboard queue; a negedge monitor decodes every frame on the
// line, checks each sample of each bit slot, and checks tx_done timing.
module tb_uart_tx_word;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = 10;
    localparam int FRAME    = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst_p = 1'b1;
    logic        word_valid = 1'b0;
    logic [31:0] word_data = '0;
    logic        word_ready;
    logic        uart_tx;
    logic        tx_busy;
    logic        tx_done;

    always #5 clk = ~clk;

    uart_tx_word #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD),
        .WORD_BYTES(4)
    ) dut (
        .clk       (clk),
        .rst_p     (rst_p),
        .word_valid(word_valid),
        .word_data (word_data),
        .word_ready(word_ready),
        .uart_tx   (uart_tx),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", name, why);
    endtask

    // Scoreboard
    logic [7:0] exp_byte_q[$];
    int         exp_done_q[$];

    int   ncyc = 0;
    int   acc_cnt = 0;
    int   done_cnt = 0;
    int   frame_cnt = 0;
    int   hi_run = 0;
    int   last_acc_run = 0;
    int   last_acc_cyc = 0;
    int   last_done_cyc = -1;
    logic prev_line = 1'b1;
    bit   in_frame = 1'b0;
    int   smp_idx = 0;
    logic samples [FRAME];

    task automatic check_frame();
        logic [7:0] got;
        logic [7:0] exp;
        logic       v;
        int         bad;
        got = '0;
        for (int b = 0; b < 8; b++) got[b] = samples[CPB + CPB*b + CPB/2];
        frame_cnt++;
        if (exp_byte_q.size() == 0) begin
            fail_now("frame_expected", $sformatf("unexpected frame 0x%02h", got));
        end else begin
            exp = exp_byte_q.pop_front();
            bad = 0;
            for (int s = 0; s < 10; s++) begin
                v = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : exp[s-1];
                for (int k = 0; k < CPB; k++)
                    if (samples[CPB*s + k] !== v) bad++;
            end
            $display("frame %0d: byte 0x%02h (expected 0x%02h) at cycle %0d", frame_cnt, got, exp, ncyc);
            check("frame_byte", {24'd0, got}, {24'd0, exp});
            check("frame_bit_samples_off", bad, 0);
        end
    endtask

    // Monitor: line decoder, accept tracker and tx_done timing checker
    always @(negedge clk) begin
        ncyc++;
        if (uart_tx === 1'b1) hi_run++;
        else hi_run = 0;
        if (rst_p) begin
            in_frame = 1'b0;
            prev_line = 1'b1;
            exp_byte_q.delete();
            exp_done_q.delete();
        end else begin
            if (tx_done === 1'b1) begin
                done_cnt++;
                last_done_cyc = ncyc;
                $display("tx_done at cycle %0d", ncyc);
                if (exp_done_q.size() == 0) fail_now("tx_done_expected", "tx_done with no word in flight");
                else check("tx_done_cycle", ncyc, exp_done_q.pop_front());
            end
            if (word_valid === 1'b1 && word_ready === 1'b1) begin
                acc_cnt++;
                last_acc_cyc = ncyc;
                last_acc_run = hi_run;
                exp_done_q.push_back(ncyc + 4*FRAME + 1);
                $display("accept word 0x%08h at cycle %0d", word_data, ncyc);
            end
            if (!in_frame) begin
                if (prev_line === 1'b1 && uart_tx === 1'b0) begin
                    in_frame = 1'b1;
                    samples[0] = 1'b0;
                    smp_idx = 1;
                end
            end else begin
                samples[smp_idx] = uart_tx;
                smp_idx++;
                if (smp_idx == FRAME) begin
                    in_frame = 1'b0;
                    check_frame();
                end
            end
            prev_line = uart_tx;
        end
    end

    task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        exp_byte_q.push_back(b0);
        exp_byte_q.push_back(b1);
        exp_byte_q.push_back(b2);
        exp_byte_q.push_back(b3);
    endtask

    task automatic wait_accept(input int limit);
        int a0;
        int n;
        a0 = acc_cnt;
        n = 0;
        while (acc_cnt == a0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (acc_cnt == a0) fail_now("accept_timeout", $sformatf("no accept within %0d cycles", limit));
    endtask

    task automatic wait_done(input int limit);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (done_cnt == d0) fail_now("done_timeout", $sformatf("no tx_done within %0d cycles", limit));
    endtask

    task automatic send_word(input logic [31:0] w, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        @(posedge clk); #1;
        push_bytes(b0, b1, b2, b3);
        word_data  = w;
        word_valid = 1'b1;
        wait_accept(100);
        word_valid = 1'b0;
    endtask

    initial begin
        int bad;
        int a0;
        int d0;
        int f0;

        // Reset state
        rst_p = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_uart_tx", uart_tx, 1);
        check("reset_tx_busy", tx_busy, 0);
        check("reset_tx_done", tx_done, 0);
        check("reset_word_ready", word_ready, 1);
        rst_p = 1'b0;

        // Power-on idle with no stimulus
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        check("idle_1000_bad_cycles", bad, 0);

        // Basic word, all-zero and all-one words
        send_word(32'h1234_5678, 8'h78, 8'h56, 8'h34, 8'h12);
        wait_done(500);
        send_word(32'h0000_0000, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_done(500);
        send_word(32'hFFFF_FFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        wait_done(500);

        // Back-to-back: word_valid held, B presented while A is on the line
        @(posedge clk); #1;
        push_bytes(8'h78, 8'h56, 8'h34, 8'h12);
        word_data  = 32'h1234_5678;
        word_valid = 1'b1;
        wait_accept(100);
        word_data = 32'hA55A_C33C;
        push_bytes(8'h3C, 8'hC3, 8'h5A, 8'hA5);
        wait_accept(600);
        word_valid = 1'b0;
        check("b2b_accept_on_done_cycle", last_acc_cyc, last_done_cyc);
        check("b2b_line_high_cycles", last_acc_run, 11);
        wait_done(500);

        // Inputs toggled while busy must have no effect
        a0 = acc_cnt;
        send_word(32'hDEAD_BEEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE);
        for (int i = 0; i < 5; i++) begin
            repeat (37) @(posedge clk);
            #1;
            word_data  = 32'h1111_1111 * (i + 1);
            word_valid = 1'b1;
            if (i == 0) begin
                check("busy_tx_busy", tx_busy, 1);
                check("busy_word_ready", word_ready, 0);
            end
            @(posedge clk); #1;
            word_valid = 1'b0;
        end
        wait_done(500);
        check("busy_accept_count", acc_cnt - a0, 1);

        // Reset during byte 2: line high at once, word discarded, no tx_done
        f0 = frame_cnt;
        send_word(32'hCAFE_F00D, 8'h0D, 8'hF0, 8'hFE, 8'hCA);
        repeat (205) @(posedge clk);
        #1;
        d0 = done_cnt;
        rst_p = 1'b1;
        #1;
        check("midreset_uart_tx", uart_tx, 1);
        check("midreset_word_ready", word_ready, 1);
        check("midreset_tx_busy", tx_busy, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_p = 1'b0;
        repeat (500) @(negedge clk);
        check("midreset_no_tx_done", done_cnt, d0);
        check("midreset_frames_sent", frame_cnt - f0, 2);
        send_word(32'h89AB_CDEF, 8'hEF, 8'hCD, 8'hAB, 8'h89);
        wait_done(500);

        repeat (20) @(posedge clk);
        check("pending_bytes", exp_byte_q.size(), 0);
        check("pending_done", exp_done_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
